ctrl_unit: RTL

Command sequencer behind `decode`. It holds the three image-job configuration registers written by decoded register-write instructions. It accepts the `begin_rdn_load`, `begin_dnn_load` and `begin_proc` commands and sequences the RDN weight loader, the DNN weight loader and per-image processing. It back-pressures instruction fetch through `ready` while any sequence is running.

---
 rtl/ctrl_unit_if.sv | 43 ++++
 rtl/ctrl_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_if.sv
// Signal bundle between decode, the weight loaders, the image engine and ctrl_unit.
// ctrl_unit takes the slave side; the surrounding system drives the master side.
interface ctrl_unit_if #(
   parameter int unsigned ADDR_W = 28
);
   logic [1:0]        reg_sel;
   logic              wr_en;
   logic [ADDR_W-1:0] reg_databus;
   logic              begin_rdn_load;
   logic              begin_dnn_load;
   logic              begin_proc;
   logic              ready;
   logic              rdn_load_start;
   logic              rdn_load_done;
   logic              dnn_load_start;
   logic              dnn_load_done;
   logic              img_start;
   logic [ADDR_W-1:0] img_addr;
   logic [ADDR_W-1:0] res_addr;
   logic              img_done;
   logic              proc_done;
   logic              rdn_loaded;
   logic              dnn_loaded;
   logic              err;

   modport master (
      output reg_sel, wr_en, reg_databus,
             begin_rdn_load, begin_dnn_load, begin_proc,
             rdn_load_done, dnn_load_done, img_done,
      input  ready, rdn_load_start, dnn_load_start,
             img_start, img_addr, res_addr,
             proc_done, rdn_loaded, dnn_loaded, err
   );

   modport slave (
      input  reg_sel, wr_en, reg_databus,
             begin_rdn_load, begin_dnn_load, begin_proc,
             rdn_load_done, dnn_load_done, img_done,
      output ready, rdn_load_start, dnn_load_start,
             img_start, img_addr, res_addr,
             proc_done, rdn_loaded, dnn_loaded, err
   );
endinterface

// File: rtl/ctrl_unit.sv
// Command sequencer: holds the image-job config registers and sequences the
// RDN/DNN weight loads and per-image processing, stalling fetch via ready.
module ctrl_unit #(
   parameter int unsigned       ADDR_W     = 28,
   parameter logic [ADDR_W-1:0] IMG_STRIDE = ADDR_W'(28'h400),
   parameter logic [ADDR_W-1:0] RES_STRIDE = ADDR_W'(28'h010)
) (
   input  logic       clk,
   input  logic       rst_n,
   ctrl_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RDN_LOAD,
      S_DNN_LOAD,
      S_PROC_ISSUE,
      S_PROC_WAIT,
      S_PROC_END
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] img_base_q;
   logic [ADDR_W-1:0] img_cnt_q;
   logic [ADDR_W-1:0] res_base_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] img_addr_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic              ready_q;
   logic              rdn_start_q;
   logic              dnn_start_q;
   logic              img_start_q;
   logic              proc_done_q;
   logic              rdn_loaded_q;
   logic              dnn_loaded_q;
   logic              err_q;

   logic [ADDR_W-1:0] img_base_d;
   logic [ADDR_W-1:0] img_cnt_d;
   logic [ADDR_W-1:0] res_base_d;
   logic [ADDR_W-1:0] idx_inc;
   logic              wr_ok;

   // A write in the same cycle as a command must be visible to that command,
   // so the command path reads these post-write values rather than the _q copies.
   always_comb begin
      wr_ok      = bus.wr_en && ready_q;
      img_base_d = img_base_q;
      img_cnt_d  = img_cnt_q;
      res_base_d = res_base_q;
      if (wr_ok) begin
         case (bus.reg_sel)
            2'd0:    img_base_d = bus.reg_databus;
            2'd1:    img_cnt_d  = bus.reg_databus;
            2'd2:    res_base_d = bus.reg_databus;
            default: ;
         endcase
      end
   end

   assign idx_inc = idx_q + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         img_base_q   <= '0;
         img_cnt_q    <= '0;
         res_base_q   <= '0;
         idx_q        <= '0;
         img_addr_q   <= '0;
         res_addr_q   <= '0;
         ready_q      <= 1'b1;
         rdn_start_q  <= 1'b0;
         dnn_start_q  <= 1'b0;
         img_start_q  <= 1'b0;
         proc_done_q  <= 1'b0;
         rdn_loaded_q <= 1'b0;
         dnn_loaded_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         img_base_q <= img_base_d;
         img_cnt_q  <= img_cnt_d;
         res_base_q <= res_base_d;

         case (state_q)
            S_IDLE: begin
               if (bus.begin_rdn_load) begin
                  state_q      <= S_RDN_LOAD;
                  ready_q      <= 1'b0;
                  rdn_start_q  <= 1'b1;
                  rdn_loaded_q <= 1'b0;
                  err_q        <= 1'b0;
               end else if (bus.begin_dnn_load) begin
                  state_q      <= S_DNN_LOAD;
                  ready_q      <= 1'b0;
                  dnn_start_q  <= 1'b1;
                  dnn_loaded_q <= 1'b0;
                  err_q        <= 1'b0;
               end else if (bus.begin_proc) begin
                  if (rdn_loaded_q && dnn_loaded_q) begin
                     ready_q <= 1'b0;
                     err_q   <= 1'b0;
                     idx_q   <= '0;
                     if (img_cnt_d != '0) begin
                        state_q     <= S_PROC_ISSUE;
                        img_start_q <= 1'b1;
                        img_addr_q  <= img_base_d;
                        res_addr_q  <= res_base_d;
                     end else begin
                        state_q     <= S_PROC_END;
                        proc_done_q <= 1'b1;
                     end
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end

            // The done strobe is not trusted during the start-pulse cycle itself.
            S_RDN_LOAD: begin
               rdn_start_q <= 1'b0;
               if (bus.rdn_load_done && !rdn_start_q) begin
                  state_q      <= S_IDLE;
                  ready_q      <= 1'b1;
                  rdn_loaded_q <= 1'b1;
               end
            end

            S_DNN_LOAD: begin
               dnn_start_q <= 1'b0;
               if (bus.dnn_load_done && !dnn_start_q) begin
                  state_q      <= S_IDLE;
                  ready_q      <= 1'b1;
                  dnn_loaded_q <= 1'b1;
               end
            end

            S_PROC_ISSUE: begin
               img_start_q <= 1'b0;
               state_q     <= S_PROC_WAIT;
            end

            // Addresses advance as running sums so no multiplier is needed.
            S_PROC_WAIT: begin
               if (bus.img_done) begin
                  idx_q <= idx_inc;
                  if (idx_inc == img_cnt_q) begin
                     state_q     <= S_PROC_END;
                     proc_done_q <= 1'b1;
                  end else begin
                     state_q     <= S_PROC_ISSUE;
                     img_start_q <= 1'b1;
                     img_addr_q  <= img_addr_q + IMG_STRIDE;
                     res_addr_q  <= res_addr_q + RES_STRIDE;
                  end
               end
            end

            S_PROC_END: begin
               proc_done_q <= 1'b0;
               state_q     <= S_IDLE;
               ready_q     <= 1'b1;
            end

            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready          = ready_q;
   assign bus.rdn_load_start = rdn_start_q;
   assign bus.dnn_load_start = dnn_start_q;
   assign bus.img_start      = img_start_q;
   assign bus.img_addr       = img_addr_q;
   assign bus.res_addr       = res_addr_q;
   assign bus.proc_done      = proc_done_q;
   assign bus.rdn_loaded     = rdn_loaded_q;
   assign bus.dnn_loaded     = dnn_loaded_q;
   assign bus.err            = err_q;

endmodule
